// File: rtl/vga_sync_receiver.sv
// Genlock receiver: synchronises external hsync/vsync, qualifies line/frame timing,
// and flywheels an x/y raster phase-locked to the source.
module vga_sync_receiver #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter bit SYNC_ACTIVE  = 1'b0,
  parameter int LATENCY      = 3,
  parameter int LOCK_FRAMES  = 2,
  parameter int MISS_LIMIT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blank,
  output logic       locked,
  output logic       line_start,
  output logic       frame_start,
  output logic       error
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic        INACTIVE  = ~SYNC_ACTIVE;
  localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_RELOAD  = 10'(H_SYNC_START + LATENCY);
  localparam logic [9:0]  X_ALIGN   = 10'(H_SYNC_START + LATENCY - 1);
  localparam logic [9:0]  Y_RELOAD  = 10'(V_SYNC_START);
  localparam logic [9:0]  X_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]  Y_VIS     = 10'(V_VISIBLE);
  localparam logic [10:0] P_NOM     = 11'(H_TOTAL);
  localparam logic [10:0] P_MAX     = '1;
  localparam logic [9:0]  LINES_NOM = 10'(V_TOTAL);
  localparam logic [7:0]  GOOD_LOCK = 8'(LOCK_FRAMES);
  localparam logic [7:0]  MISS_MAX  = 8'(MISS_LIMIT);

  logic        r_hs_meta, r_hs_sync, r_hs_prev;
  logic        r_vs_meta, r_vs_sync, r_vs_prev;
  state_t      r_state, w_state_next;
  logic [9:0]  r_x, r_y, w_x_next, w_y_next;
  logic [10:0] r_period, w_period_next;
  logic [9:0]  r_lines, w_lines_next, w_lines_inc;
  logic        r_bad, w_bad_next, w_bad_inc;
  logic [7:0]  r_good, w_good_next, w_good_inc;
  logic        r_seen, w_seen_next, w_seen_eff;
  logic [7:0]  r_miss, w_miss_next, w_miss_inc;
  logic        r_line_start, r_frame_start, r_error, w_error_next;
  logic        w_hs_edge, w_vs_edge, w_x_wrap;

  assign w_hs_edge   = (r_hs_sync == SYNC_ACTIVE) && (r_hs_prev != SYNC_ACTIVE);
  assign w_vs_edge   = (r_vs_sync == SYNC_ACTIVE) && (r_vs_prev != SYNC_ACTIVE);
  assign w_x_wrap    = (r_x == X_LAST);
  assign w_lines_inc = r_lines + {9'd0, w_hs_edge};
  assign w_bad_inc   = r_bad | (w_hs_edge && (r_period != P_NOM));
  assign w_good_inc  = r_good + 8'd1;
  assign w_miss_inc  = r_miss + 8'd1;
  assign w_seen_eff  = r_seen | (w_hs_edge && (r_x == X_ALIGN));

  always_comb begin
    w_state_next  = r_state;
    w_x_next      = w_x_wrap ? '0 : r_x + 10'd1;
    w_y_next      = w_x_wrap ? ((r_y == Y_LAST) ? '0 : r_y + 10'd1) : r_y;
    w_period_next = w_hs_edge ? 11'd1 : ((r_period == P_MAX) ? P_MAX : r_period + 11'd1);
    w_lines_next  = r_lines;
    w_bad_next    = r_bad;
    w_good_next   = r_good;
    w_seen_next   = r_seen;
    w_miss_next   = r_miss;
    w_error_next  = 1'b0;

    case (r_state)
      SEARCH: begin
        if (w_hs_edge) w_x_next = X_RELOAD;
        if (w_vs_edge) w_y_next = Y_RELOAD;
        w_lines_next = '0;
        w_bad_next   = 1'b0;
        w_good_next  = '0;
        w_seen_next  = 1'b0;
        w_miss_next  = '0;
        if (w_vs_edge) w_state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (w_hs_edge) w_x_next = X_RELOAD;
        if (w_vs_edge) w_y_next = Y_RELOAD;
        // The frame verdict includes an hs_edge coincident with the closing vs_edge.
        if (w_vs_edge) begin
          w_lines_next = '0;
          w_bad_next   = 1'b0;
          if ((w_lines_inc == LINES_NOM) && !w_bad_inc) begin
            w_good_next = w_good_inc;
            if (w_good_inc >= GOOD_LOCK) w_state_next = LOCKED;
          end else begin
            w_good_next = '0;
          end
        end else begin
          w_lines_next = w_lines_inc;
          w_bad_next   = w_bad_inc;
        end
      end
      LOCKED: begin
        if (w_x_wrap) begin
          w_seen_next = 1'b0;
          w_miss_next = w_seen_eff ? '0 : w_miss_inc;
          if (!w_seen_eff && (w_miss_inc >= MISS_MAX)) begin
            w_state_next = SEARCH;
            w_error_next = 1'b1;
          end
        end else begin
          w_seen_next = w_seen_eff;
        end
        if (w_vs_edge && (r_y != Y_RELOAD)) begin
          w_state_next = SEARCH;
          w_error_next = 1'b1;
        end
        if (w_state_next == SEARCH) begin
          w_seen_next = 1'b0;
          w_miss_next = '0;
          w_good_next = '0;
        end
      end
      default: w_state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_meta     <= INACTIVE;
      r_hs_sync     <= INACTIVE;
      r_hs_prev     <= INACTIVE;
      r_vs_meta     <= INACTIVE;
      r_vs_sync     <= INACTIVE;
      r_vs_prev     <= INACTIVE;
      r_state       <= SEARCH;
      r_x           <= '0;
      r_y           <= '0;
      r_period      <= '0;
      r_lines       <= '0;
      r_bad         <= 1'b0;
      r_good        <= '0;
      r_seen        <= 1'b0;
      r_miss        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_hs_meta     <= hsync_in;
      r_hs_sync     <= r_hs_meta;
      r_hs_prev     <= r_hs_sync;
      r_vs_meta     <= vsync_in;
      r_vs_sync     <= r_vs_meta;
      r_vs_prev     <= r_vs_sync;
      r_state       <= w_state_next;
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_period      <= w_period_next;
      r_lines       <= w_lines_next;
      r_bad         <= w_bad_next;
      r_good        <= w_good_next;
      r_seen        <= w_seen_next;
      r_miss        <= w_miss_next;
      r_line_start  <= (w_state_next == LOCKED) && (w_x_next == '0);
      r_frame_start <= (w_state_next == LOCKED) && (w_x_next == '0) && (w_y_next == '0);
      r_error       <= w_error_next;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign locked      = (r_state == LOCKED);
  assign blank       = !locked || (r_x >= X_VIS) || (r_y >= Y_VIS);
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign error       = r_error;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced raster: a behavioural sync source drives
// both an active-low and an active-high instance; lock timing is predicted from source events.
module tb_vga_sync_receiver;

  localparam int HV = 16, HSS = 20, HSW = 4, HT = 32;
  localparam int VV = 10, VSS = 12, VSW = 2, VT = 16;
  localparam int LAT = 3, LOCKF = 2, MISSL = 4;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs0, vs0, hs1, vs1;
  logic [9:0] x0, y0, x1, y1;
  logic       blank0, locked0, ls0, fs0, err0;
  logic       blank1, locked1, ls1, fs1, err1;

  int sx = 0, sy = 0, cyc = 0;
  int drop_left = 0, hs_dly = 0, vs_off = 0;
  bit short_pend = 0, hs_act = 0, vs_act = 0, vs_rise = 0;
  int errors = 0, checks = 0;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_TOTAL(VT),
    .SYNC_ACTIVE(1'b0), .LATENCY(LAT), .LOCK_FRAMES(LOCKF), .MISS_LIMIT(MISSL)
  ) u_dut0 (
    .clk(clk), .rst(rst), .hsync_in(hs0), .vsync_in(vs0),
    .x(x0), .y(y0), .blank(blank0), .locked(locked0),
    .line_start(ls0), .frame_start(fs0), .error(err0)
  );

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_TOTAL(VT),
    .SYNC_ACTIVE(1'b1), .LATENCY(LAT), .LOCK_FRAMES(LOCKF), .MISS_LIMIT(MISSL)
  ) u_dut1 (
    .clk(clk), .rst(rst), .hsync_in(hs1), .vsync_in(vs1),
    .x(x1), .y(y1), .blank(blank1), .locked(locked1),
    .line_start(ls1), .frame_start(fs1), .error(err1)
  );

  always #5 clk = ~clk;

  // Source pins from the source position and the active impairments.
  task automatic drive();
    int hx;
    hx     = (sx - hs_dly + HT) % HT;
    hs_act = (drop_left == 0) && (hx >= HSS) && (hx < HSS + HSW);
    vs_act = (sy >= VSS + vs_off) && (sy < VSS + vs_off + VSW);
    hs0 = ~hs_act; vs0 = ~vs_act;
    hs1 = hs_act;  vs1 = vs_act;
  endtask

  task automatic step();
    bit wrap, prev;
    @(posedge clk); #1;
    cyc++;
    wrap = (sx == HT - 1) || (short_pend && (sy == 3) && (sx == HT - 2));
    if (wrap) begin
      if (sx == HT - 2) short_pend = 0;
      sx = 0;
      sy = (sy == VT - 1) ? 0 : sy + 1;
      if (drop_left > 0) drop_left--;
    end else begin
      sx++;
    end
    prev = vs_act;
    drive();
    vs_rise = vs_act && !prev;
  endtask

  task automatic wait_pos(input int px, input int py);
    bit hit;
    hit = (sx == px) && (sy == py);
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      step();
      hit = (sx == px) && (sy == py);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_pos timeout got=(%0d,%0d) exp=(%0d,%0d)", sx, sy, px, py);
    end
  endtask

  // Lock is expected 3 cycles after the source's vsync rise that closes the
  // LOCK_FRAMES-th good frame, counting rises seen from SEARCH onward.
  task automatic relock(input int extra_bad, input string nm);
    int need, n, t_exp;
    bit early, done;
    need = 1 + LOCKF + extra_bad; n = 0; t_exp = -1; early = 0; done = 0;
    for (int i = 0; i < (need + 2) * FRAME && !done; i++) begin
      step();
      if (vs_rise) begin
        n++;
        if (n == 1 && extra_bad > 0) short_pend = 1;
        if (n == need) t_exp = cyc + 3;
      end
      if (t_exp < 0 || cyc < t_exp) begin
        if (locked0 || locked1) early = 1;
      end else begin
        done = 1;
        checks++;
        if (locked0 !== 1'b1) begin errors++; $display("FAIL %s_lock0 got=%b exp=1 cyc=%0d", nm, locked0, cyc); end
        checks++;
        if (locked1 !== 1'b1) begin errors++; $display("FAIL %s_lock1 got=%b exp=1 cyc=%0d", nm, locked1, cyc); end
      end
    end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL %s_early got=%b exp=0", nm, early); end
    checks++;
    if (!done) begin errors++; $display("FAIL %s_timeout got=%0d rises exp=%0d", nm, n, need); end
  endtask

  // Per-cycle comparison of the recovered raster against the source (offset by dly).
  task automatic check_track(input int ncyc, input int dly, input string nm);
    int ex, last_l, last_f;
    bit eb;
    last_l = -1; last_f = -1;
    for (int i = 0; i < ncyc; i++) begin
      step();
      ex = (sx - dly + HT) % HT;
      checks++;
      if (x0 !== 10'(ex)) begin errors++; $display("FAIL %s_x cyc=%0d got=%0d exp=%0d", nm, cyc, x0, ex); end
      checks++;
      if (x1 !== 10'(ex)) begin errors++; $display("FAIL %s_x1 cyc=%0d got=%0d exp=%0d", nm, cyc, x1, ex); end
      checks++;
      if (locked0 !== 1'b1 || err0 !== 1'b0) begin
        errors++; $display("FAIL %s_lock cyc=%0d got=%b/%b exp=1/0", nm, cyc, locked0, err0);
      end
      if (dly == 0) begin
        eb = (ex >= HV) || (sy >= VV);
        checks++;
        if (y0 !== 10'(sy)) begin errors++; $display("FAIL %s_y cyc=%0d got=%0d exp=%0d", nm, cyc, y0, sy); end
        checks++;
        if (blank0 !== eb) begin errors++; $display("FAIL %s_blank cyc=%0d got=%b exp=%b", nm, cyc, blank0, eb); end
        checks++;
        if (ls0 !== (sx == 0)) begin errors++; $display("FAIL %s_line_start cyc=%0d got=%b exp=%b", nm, cyc, ls0, sx == 0); end
        checks++;
        if (fs0 !== (sx == 0 && sy == 0)) begin
          errors++; $display("FAIL %s_frame_start cyc=%0d got=%b exp=%b", nm, cyc, fs0, sx == 0 && sy == 0);
        end
        if (ls0 === 1'b1) begin
          if (last_l >= 0) begin
            checks++;
            if (cyc - last_l != HT) begin errors++; $display("FAIL %s_line_period got=%0d exp=%0d", nm, cyc - last_l, HT); end
          end
          last_l = cyc;
        end
        if (fs0 === 1'b1) begin
          if (last_f >= 0) begin
            checks++;
            if (cyc - last_f != FRAME) begin errors++; $display("FAIL %s_frame_period got=%0d exp=%0d", nm, cyc - last_f, FRAME); end
          end
          last_f = cyc;
        end
      end
    end
  endtask

  // Four missing aligned pulses starting at line 2: error at the start of line 6.
  task automatic expect_loss_line6(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      step();
      if (sx == HT - 1 && sy == 5) begin
        checks++;
        if (locked0 !== 1'b1 || err0 !== 1'b0) begin
          errors++; $display("FAIL %s_pre got=%b/%b exp=1/0", nm, locked0, err0);
        end
      end
      if (sx == 0 && sy == 6) begin
        seen = 1;
        checks++;
        if (err0 !== 1'b1 || locked0 !== 1'b0) begin
          errors++; $display("FAIL %s_error got=%b/%b exp=1/0", nm, err0, locked0);
        end
        step();
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL %s_pulse got=%b exp=0", nm, err0); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout got=0 exp=1", nm); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (x0 !== 10'd0 || y0 !== 10'd0) begin errors++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", x0, y0); end
    checks++;
    if (blank0 !== 1'b1 || locked0 !== 1'b0) begin errors++; $display("FAIL reset_blank_locked got=%b%b exp=10", blank0, locked0); end
    checks++;
    if (ls0 !== 1'b0 || fs0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got=%b%b%b exp=000", ls0, fs0, err0);
    end
    checks++;
    if (blank1 !== 1'b1 || locked1 !== 1'b0 || x1 !== 10'd0) begin
      errors++; $display("FAIL reset_inst1 got=%b%b%0d exp=10,0", blank1, locked1, x1);
    end
  endtask

  task automatic test_acquire();
    do sy = $urandom_range(VT - 1, 0); while (sy >= VSS - 1 && sy <= VSS + VSW);
    sx = $urandom_range(HT - 1, 0);
    drive();
    step();
    rst = 1'b0;
    relock(0, "acq");
    check_track(2 * FRAME, 0, "acq");
  endtask

  task automatic test_drop3();
    wait_pos(0, 2);
    drop_left = 3;
    drive();
    check_track(6 * HT, 0, "drop3");
  endtask

  task automatic test_drop4();
    wait_pos(0, 2);
    drop_left = 4;
    drive();
    expect_loss_line6("drop4");
    relock(0, "drop4_relock");
    check_track(FRAME, 0, "drop4_track");
  endtask

  task automatic test_reset_mid();
    wait_pos(5, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (x0 !== 10'd0 || y0 !== 10'd0 || blank0 !== 1'b1 || locked0 !== 1'b0) begin
      errors++; $display("FAIL midreset got=%0d,%0d,%b,%b exp=0,0,1,0", x0, y0, blank0, locked0);
    end
    relock(0, "midreset_relock");
    check_track(HT * 4, 0, "midreset_track");
  endtask

  task automatic test_vsync_move();
    bit hit;
    wait_pos(0, 0);
    vs_off = 1;
    drive();
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      step();
      hit = vs_rise;
    end
    step(); step();
    checks++;
    if (locked0 !== 1'b1) begin errors++; $display("FAIL vmove_pre got=%b exp=1", locked0); end
    step();
    checks++;
    if (!hit || err0 !== 1'b1 || locked0 !== 1'b0) begin
      errors++; $display("FAIL vmove_error got=%b/%b exp=1/0", err0, locked0);
    end
    step();
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL vmove_pulse got=%b exp=0", err0); end
    wait_pos(0, 0);
    vs_off = 0;
    drive();
    rst = 1'b1;
    step();
    rst = 1'b0;
    relock(1, "shortline");
  endtask

  task automatic test_delay();
    wait_pos(0, 2);
    hs_dly = 5;
    drive();
    expect_loss_line6("delay");
    relock(0, "delay_relock");
    check_track(FRAME, 5, "delay_track");
  endtask

  initial begin
    drive();
    test_reset();
    test_acquire();
    test_drop3();
    test_drop4();
    test_reset_mid();
    test_vsync_move();
    test_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
